// File: rtl/rs485_pkg.sv
// Shared encodings and constants for the RS485 command receiver.
package rs485_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
  typedef enum logic [1:0] {P_ADDR, P_LO, P_HI} pkt_state_t;

  localparam logic FLAG_ADDR  = 1'b1;
  localparam logic FLAG_DATA  = 1'b0;
  localparam int   FRAME_BITS = 11;

  // A bit period shorter than two clocks cannot hold a mid-bit sample point.
  function automatic logic [7:0] eff_cpb(input logic [7:0] v);
    return (v < 8'd2) ? 8'd2 : v;
  endfunction

endpackage

// File: rtl/rs485_frame_rx.sv
// Synchroniser and bit-level FSM: turns the raw line into 11-bit frames
// ({flag, data} plus a frame_ok or frame_err pulse on the stop-bit sample).
module rs485_frame_rx
  import rs485_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] clk_per_bit,
  output logic [8:0] frame,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] cpb
);

  logic       rx_meta;
  logic       rx_s;
  bit_state_t state_q;
  bit_state_t state_d;
  logic [7:0] cnt;
  logic [7:0] cpb_l;
  logic [3:0] bit_idx;
  logic [8:0] shreg;
  logic       cnt_end;
  logic       cnt_mid;

  assign cnt_end = (cnt == cpb_l - 8'd1);
  assign cnt_mid = (cnt == ((cpb_l - 8'd1) >> 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (cnt_mid) state_d = rx_s ? IDLE : DATA;
      DATA:    if (cnt_end && bit_idx == 4'(FRAME_BITS - 3)) state_d = STOP;
      STOP:    if (cnt_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cnt     <= 8'd0;
      bit_idx <= 4'd0;
      cpb_l   <= 8'd2;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt     <= 8'd0;
          bit_idx <= 4'd0;
          if (!rx_s) cpb_l <= eff_cpb(clk_per_bit);
        end
        START: cnt <= cnt_mid ? 8'd0 : cnt + 8'd1;
        DATA: begin
          if (cnt_end) begin
            cnt     <= 8'd0;
            bit_idx <= bit_idx + 4'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP:    cnt <= cnt_end ? 8'd0 : cnt + 8'd1;
        default: cnt <= 8'd0;
      endcase
    end
  end

  // LSB arrives first, so bits enter at the top; the flag ends up in bit 8.
  always_ff @(posedge clk) begin
    if (state_q == DATA && cnt_end) shreg <= {rx_s, shreg[8:1]};
  end

  assign frame     = shreg;
  assign frame_ok  = (state_q == STOP) && cnt_end && rx_s;
  assign frame_err = (state_q == STOP) && cnt_end && !rx_s;
  assign busy      = (state_q != IDLE);
  assign cpb       = cpb_l;

endmodule

// File: rtl/rs485_cmd_receiver.sv
// RS485 addressed command receiver: address frame, lo byte, hi byte -> cmd_word.
// Optional RS485_RX_TIMEOUT_EN drops a partial packet after TIMEOUT_BITS idle bit times.
module rs485_cmd_receiver
  import rs485_pkg::*;
#(
  parameter int TIMEOUT_BITS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [7:0]  clk_per_bit,
  input  logic [7:0]  slave_addr,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  output logic        addr_match,
  output logic        frame_err,
  output logic        busy
);

  logic [8:0] frame;
  logic       f_ok;
  logic       f_err;
  logic [7:0] cpb;
  pkt_state_t pkt_q;
  pkt_state_t pkt_d;
  logic [7:0] lo_byte;
  logic       is_match;
  logic       is_cmd;
  logic       is_lo;
  logic       tmo_hit;

  rs485_frame_rx u_frame_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .clk_per_bit (clk_per_bit),
    .frame       (frame),
    .frame_ok    (f_ok),
    .frame_err   (f_err),
    .busy        (busy),
    .cpb         (cpb)
  );

`ifdef RS485_RX_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_lim;

  assign tmo_lim = 16'(TIMEOUT_BITS) * {8'd0, cpb};
  assign tmo_hit = (pkt_q != P_ADDR) && !busy && (tmo_cnt == tmo_lim - 16'd1);

  // Idle time only accumulates between frames of a partially received packet.
  always_ff @(posedge clk) begin
    if (!rst || pkt_q == P_ADDR || busy) tmo_cnt <= 16'd0;
    else                                 tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_BITS == 0) ^ (^cpb);
  assign tmo_hit    = 1'b0;
`endif

  assign is_match = f_ok && (frame[8] == FLAG_ADDR) && (frame[7:0] == slave_addr);
  assign is_lo    = f_ok && (frame[8] == FLAG_DATA) && (pkt_q == P_LO);
  assign is_cmd   = f_ok && (frame[8] == FLAG_DATA) && (pkt_q == P_HI);

  always_comb begin
    pkt_d = pkt_q;
    if (f_err) begin
      pkt_d = P_ADDR;
    end else if (f_ok) begin
      if (frame[8] == FLAG_ADDR) begin
        pkt_d = is_match ? P_LO : P_ADDR;
      end else begin
        case (pkt_q)
          P_LO:    pkt_d = P_HI;
          P_HI:    pkt_d = P_ADDR;
          default: pkt_d = P_ADDR;
        endcase
      end
    end else if (tmo_hit) begin
      pkt_d = P_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_q      <= P_ADDR;
      addr_match <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      cmd_word   <= 16'd0;
    end else begin
      pkt_q      <= pkt_d;
      addr_match <= is_match;
      cmd_valid  <= is_cmd;
      frame_err  <= f_err;
      if (is_cmd) cmd_word <= {frame[7:0], lo_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (is_lo) lo_byte <= frame[7:0];
  end

endmodule

// File: tb/tb_rs485_cmd_receiver.sv
// Directed bench for rs485_cmd_receiver: serial frames in, pulse counts and cmd_word checked.
module tb_rs485_cmd_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [7:0]  clk_per_bit = 8'd25;
  logic [7:0]  slave_addr  = 8'h02;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        addr_match;
  logic        frame_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int n_am = 0;
  int n_cv = 0;
  int n_fe = 0;
  logic [7:0] mid_cpb = 8'd0;

  rs485_cmd_receiver #(.TIMEOUT_BITS(22)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .clk_per_bit (clk_per_bit),
    .slave_addr  (slave_addr),
    .cmd_word    (cmd_word),
    .cmd_valid   (cmd_valid),
    .addr_match  (addr_match),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (addr_match === 1'b1) n_am++;
    if (cmd_valid  === 1'b1) n_cv++;
    if (frame_err  === 1'b1) n_fe++;
  end

  task automatic send_frame(input logic [7:0] d, input logic flag, input logic stop, input int bitw);
    logic [10:0] bits;
    bits = {stop, flag, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      if (i == 2 && mid_cpb != 8'd0) clk_per_bit = mid_cpb;
      repeat (bitw) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * bitw + 6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (cmd_word !== 16'h0000) begin failures++; $display("FAIL reset_cmd_word got=%h exp=0000", cmd_word); end
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    checks++; if (addr_match !== 1'b0) begin failures++; $display("FAIL reset_addr_match got=%b exp=0", addr_match); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    int am0, cv0, fe0;
    am0 = n_am; cv0 = n_cv; fe0 = n_fe;
    send_frame(8'h02, 1'b1, 1'b1, 25);
    checks++; if (n_am - am0 !== 1) begin failures++; $display("FAIL basic_addr_match got=%0d exp=1", n_am - am0); end
    send_frame(8'h34, 1'b0, 1'b1, 25);
    send_frame(8'h12, 1'b0, 1'b1, 25);
    checks++; if (n_cv - cv0 !== 1) begin failures++; $display("FAIL basic_cmd_valid got=%0d exp=1", n_cv - cv0); end
    checks++; if (cmd_word !== 16'h1234) begin failures++; $display("FAIL basic_cmd_word got=%h exp=1234", cmd_word); end
    checks++; if (n_fe - fe0 !== 0) begin failures++; $display("FAIL basic_frame_err got=%0d exp=0", n_fe - fe0); end
  endtask

  task automatic test_wrong_addr;
    int am0, cv0;
    am0 = n_am; cv0 = n_cv;
    send_frame(8'h05, 1'b1, 1'b1, 25);
    send_frame(8'h34, 1'b0, 1'b1, 25);
    send_frame(8'h12, 1'b0, 1'b1, 25);
    checks++; if (n_am - am0 !== 0) begin failures++; $display("FAIL wrong_addr_match got=%0d exp=0", n_am - am0); end
    checks++; if (n_cv - cv0 !== 0) begin failures++; $display("FAIL wrong_addr_cmd_valid got=%0d exp=0", n_cv - cv0); end
    checks++; if (cmd_word !== 16'h1234) begin failures++; $display("FAIL wrong_addr_cmd_word got=%h exp=1234", cmd_word); end
  endtask

  task automatic test_frame_err;
    int am0, cv0, fe0;
    am0 = n_am; cv0 = n_cv; fe0 = n_fe;
    send_frame(8'h02, 1'b1, 1'b1, 25);
    send_frame(8'h34, 1'b0, 1'b0, 25);
    checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL ferr_pulse got=%0d exp=1", n_fe - fe0); end
    send_frame(8'h12, 1'b0, 1'b1, 25);
    checks++; if (n_am - am0 !== 1) begin failures++; $display("FAIL ferr_addr_match got=%0d exp=1", n_am - am0); end
    checks++; if (n_cv - cv0 !== 0) begin failures++; $display("FAIL ferr_cmd_valid got=%0d exp=0", n_cv - cv0); end
    checks++; if (cmd_word !== 16'h1234) begin failures++; $display("FAIL ferr_cmd_word got=%h exp=1234", cmd_word); end
  endtask

  task automatic test_glitch;
    int am0, cv0, fe0;
    logic saw_busy;
    am0 = n_am; cv0 = n_cv; fe0 = n_fe;
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    checks++; if ((n_am - am0) + (n_cv - cv0) + (n_fe - fe0) !== 0) begin
      failures++; $display("FAIL glitch_outputs got=%0d exp=0", (n_am - am0) + (n_cv - cv0) + (n_fe - fe0));
    end
  endtask

  task automatic test_readdress;
    int am0, cv0;
    am0 = n_am; cv0 = n_cv;
    send_frame(8'h02, 1'b1, 1'b1, 25);
    send_frame(8'h34, 1'b0, 1'b1, 25);
    send_frame(8'h02, 1'b1, 1'b1, 25);
    send_frame(8'h78, 1'b0, 1'b1, 25);
    send_frame(8'h56, 1'b0, 1'b1, 25);
    checks++; if (n_am - am0 !== 2) begin failures++; $display("FAIL readdr_addr_match got=%0d exp=2", n_am - am0); end
    checks++; if (n_cv - cv0 !== 1) begin failures++; $display("FAIL readdr_cmd_valid got=%0d exp=1", n_cv - cv0); end
    checks++; if (cmd_word !== 16'h5678) begin failures++; $display("FAIL readdr_cmd_word got=%h exp=5678", cmd_word); end
  endtask

  task automatic test_cpb_min;
    int am0, cv0;
    am0 = n_am; cv0 = n_cv;
    clk_per_bit = 8'd0;
    send_frame(8'h02, 1'b1, 1'b1, 2);
    clk_per_bit = 8'd1;
    send_frame(8'hCD, 1'b0, 1'b1, 2);
    send_frame(8'hAB, 1'b0, 1'b1, 2);
    clk_per_bit = 8'd25;
    checks++; if (n_am - am0 !== 1) begin failures++; $display("FAIL cpb_min_addr_match got=%0d exp=1", n_am - am0); end
    checks++; if (n_cv - cv0 !== 1) begin failures++; $display("FAIL cpb_min_cmd_valid got=%0d exp=1", n_cv - cv0); end
    checks++; if (cmd_word !== 16'hABCD) begin failures++; $display("FAIL cpb_min_cmd_word got=%h exp=abcd", cmd_word); end
  endtask

  task automatic test_cpb_change;
    int cv0;
    cv0 = n_cv;
    mid_cpb = 8'd10;
    send_frame(8'h02, 1'b1, 1'b1, 25);
    clk_per_bit = 8'd25;
    send_frame(8'h9A, 1'b0, 1'b1, 25);
    clk_per_bit = 8'd25;
    send_frame(8'hBC, 1'b0, 1'b1, 25);
    clk_per_bit = 8'd25;
    mid_cpb = 8'd0;
    checks++; if (n_cv - cv0 !== 1) begin failures++; $display("FAIL cpb_change_cmd_valid got=%0d exp=1", n_cv - cv0); end
    checks++; if (cmd_word !== 16'hBC9A) begin failures++; $display("FAIL cpb_change_cmd_word got=%h exp=bc9a", cmd_word); end
  endtask

  task automatic test_reset_mid;
    int cv0;
    logic [7:0] hi;
    cv0 = n_cv;
    hi  = 8'h12;
    send_frame(8'h02, 1'b1, 1'b1, 25);
    send_frame(8'h34, 1'b0, 1'b1, 25);
    rx = 1'b0;
    repeat (25) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = hi[i];
      repeat (25) @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy_in_reset got=%b exp=0", busy); end
    checks++; if (cmd_word !== 16'h0000) begin failures++; $display("FAIL rmid_cmd_word got=%h exp=0000", cmd_word); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1, 25);
    checks++; if (n_cv - cv0 !== 0) begin failures++; $display("FAIL rmid_cmd_valid got=%0d exp=0", n_cv - cv0); end
  endtask

  task automatic test_timeout;
    int cv0;
    cv0 = n_cv;
    send_frame(8'h02, 1'b1, 1'b1, 25);
    send_frame(8'h34, 1'b0, 1'b1, 25);
    repeat (30 * 25) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1, 25);
`ifdef RS485_RX_TIMEOUT_EN
    checks++; if (n_cv - cv0 !== 0) begin failures++; $display("FAIL timeout_cmd_valid got=%0d exp=0", n_cv - cv0); end
    checks++; if (cmd_word !== 16'h0000) begin failures++; $display("FAIL timeout_cmd_word got=%h exp=0000", cmd_word); end
`else
    checks++; if (n_cv - cv0 !== 1) begin failures++; $display("FAIL timeout_cmd_valid got=%0d exp=1", n_cv - cv0); end
    checks++; if (cmd_word !== 16'h1234) begin failures++; $display("FAIL timeout_cmd_word got=%h exp=1234", cmd_word); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrong_addr();
    test_frame_err();
    test_glitch();
    test_readdress();
    test_cpb_min();
    test_cpb_change();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
